// File: rtl/uart_loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (enables the trailing CHK byte).
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } loaderState_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_e;

  // Number of length-prefix bytes ahead of the word stream.
  localparam int LEN_BYTES = 2;
  // Initial value of the running XOR over data bytes.
  localparam logic [7:0] CHK_SEED = 8'h00;

endpackage

// File: rtl/uart_loader_if.sv
// Memory write port driven by the loader: address, data word and write strobe.
interface uart_loader_if #(
  parameter int MEM_AW = 16
);
  logic [MEM_AW-1:0] memAddr;
  logic [15:0]       memData;
  logic              memWE;

  modport master (output memAddr, output memData, output memWE);
  modport slave  (input  memAddr, input  memData, input  memWE);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling, one-cycle byteValid / frameErr strobes.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxByte,
  output logic       byteValid,
  output logic       frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  rxState_e      st, stNext;
  logic          rxMeta, rxSync, rxPrev;
  logic [CW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic          halfHit, fullHit;

  assign halfHit = (baudCnt == HALF_END);
  assign fullHit = (baudCnt == BIT_END);

  // Synchronise the asynchronous line and keep the previous value for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= RX_IDLE;
    else     st <= stNext;
  end

  // Frame sequencing: start edge, half-bit start check, 8 data bits, stop bit.
  always_comb begin
    stNext = st;
    case (st)
      RX_IDLE:  if (rxPrev && !rxSync) stNext = RX_START;
      RX_START: if (halfHit) stNext = rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (fullHit && bitIdx == 3'd7) stNext = RX_STOP;
      RX_STOP:  if (fullHit) stNext = RX_IDLE;
      default:  stNext = RX_IDLE;
    endcase
  end

  // Baud/bit counters, LSB-first shift register and the output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baudCnt   <= '0;
      bitIdx    <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      if (st == RX_IDLE || stNext != st || fullHit) baudCnt <= '0;
      else                                          baudCnt <= baudCnt + 1'b1;
      if (st == RX_START)                bitIdx <= '0;
      else if (st == RX_DATA && fullHit) bitIdx <= bitIdx + 3'd1;
      if (st == RX_DATA && fullHit) rxByte <= {rxSync, rxByte[7:1]};
      byteValid <= (st == RX_STOP) && fullHit && rxSync;
      frameErr  <= (st == RX_STOP) && fullHit && !rxSync;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Serial program loader: length-prefixed big-endian word stream over UART,
// written to memory from address 0; holds the CPU in reset until complete.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR check byte after the image).
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int MEM_AW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_loader_if.master mem,
  output logic          cpuRst,
  output logic          done,
  output logic          error
);

`ifdef LOADER_CHECKSUM_EN
  localparam loaderState_e AFTER_IMAGE = S_CHK;
`else
  localparam loaderState_e AFTER_IMAGE = S_DONE;
`endif

  loaderState_e state, stateNext;
  logic [7:0]   rxByte;
  logic         byteValid, frameErr;
  logic [15:0]  wordLen;
  logic [15:0]  wordCnt;
  logic [7:0]   hiByte;
  logic         wrEn;
  logic         lastWord;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]   chkAcc;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxInst (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxByte    (rxByte),
    .byteValid (byteValid),
    .frameErr  (frameErr)
  );

  assign lastWord = (wordCnt == wordLen - 16'd1);

  // Loader state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN_HI;
    else     state <= stateNext;
  end

  // Byte protocol sequencing; terminal states swallow everything until reset.
  always_comb begin
    stateNext = state;
    wrEn      = 1'b0;
    if (frameErr && state != S_DONE && state != S_ERR) begin
      stateNext = S_ERR;
    end else if (byteValid) begin
      case (state)
        S_LEN_HI:  stateNext = S_LEN_LO;
        S_LEN_LO:  stateNext = ({wordLen[15:8], rxByte} != 16'd0) ? S_DATA_HI : AFTER_IMAGE;
        S_DATA_HI: stateNext = S_DATA_LO;
        S_DATA_LO: begin
          wrEn      = 1'b1;
          stateNext = lastWord ? AFTER_IMAGE : S_DATA_HI;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK:     stateNext = (chkAcc == rxByte) ? S_DONE : S_ERR;
`endif
        default:   stateNext = state;
      endcase
    end
  end

  // Length and high-byte capture; only read after being written in this load.
  always_ff @(posedge clk) begin
    if (byteValid && state == S_LEN_HI)  wordLen[15:8] <= rxByte;
    if (byteValid && state == S_LEN_LO)  wordLen[7:0]  <= rxByte;
    if (byteValid && state == S_DATA_HI) hiByte        <= rxByte;
  end

  // Memory write port, word index and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt     <= '0;
      mem.memAddr <= '0;
      mem.memData <= '0;
      mem.memWE   <= 1'b0;
      cpuRst      <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem.memWE <= wrEn;
      if (wrEn) begin
        mem.memAddr <= MEM_AW'(wordCnt);
        mem.memData <= {hiByte, rxByte};
        wordCnt     <= wordCnt + 16'd1;
      end
      cpuRst <= (stateNext != S_DONE);
      done   <= (stateNext == S_DONE);
      error  <= (stateNext == S_ERR);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over data bytes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chkAcc <= CHK_SEED;
    else if (byteValid && (state == S_DATA_HI || state == S_DATA_LO)) chkAcc <= chkAcc ^ rxByte;
  end
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with an image-level reference model.
// Optional feature macro: LOADER_CHECKSUM_EN (must match the RTL build).
module tb_uart_loader;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpuRst, done, error;

  uart_loader_if #(.MEM_AW(16)) memBus ();

  uart_loader #(.CLKS_PER_BIT(CPB), .MEM_AW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .mem    (memBus.master),
    .cpuRst (cpuRst),
    .done   (done),
    .error  (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t expQ[$];
  int  checks   = 0;
  int  failures = 0;
  logic expDone, expErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Image-level model: from the byte list and the index of a bad-stop byte,
  // derive the writes that must appear and the final done/error status.
  function automatic void model(input logic [7:0] b[$], input int feIdx);
    int n, limit, need;
    logic [7:0] x;
    wr_t w;
    expDone = 1'b0;
    expErr  = 1'b0;
    limit   = (feIdx >= 0) ? feIdx : b.size();
    n       = (b.size() >= 2) ? int'({b[0], b[1]}) : 0;
    need    = 2 + 2 * n;
`ifdef LOADER_CHECKSUM_EN
    need    = need + 1;
`endif
    for (int k = 0; k < n; k++) begin
      if (3 + 2 * k < limit) begin
        w.addr = 16'(k);
        w.data = {b[2 + 2 * k], b[3 + 2 * k]};
        expQ.push_back(w);
      end
    end
    if (feIdx >= 0 && feIdx < need) expErr = 1'b1;
    else if (limit >= need && b.size() >= 2) begin
`ifdef LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 2; i < 2 + 2 * n; i++) x = x ^ b[i];
      if (x == b[need - 1]) expDone = 1'b1;
      else                  expErr  = 1'b1;
`else
      x = 8'h00;
      expDone = (x == 8'h00);
`endif
    end
  endfunction

  // Every cycle out of reset: each write must match the next expected one,
  // and cpuRst must be the complement of done.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      check("cpuRst_vs_done", {31'd0, cpuRst}, {31'd0, ~done});
      if (memBus.memWE === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h@%h required=none", memBus.memData, memBus.memAddr);
        end else begin
          e = expQ.pop_front();
          check("write_addr", {16'd0, memBus.memAddr}, {16'd0, e.addr});
          check("write_data", {16'd0, memBus.memData}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] v, input logic stopBit);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic glitch();
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_memAddr", {16'd0, memBus.memAddr}, 32'd0);
    check("rst_memData", {16'd0, memBus.memData}, 32'd0);
    check("rst_flags", {28'd0, memBus.memWE, cpuRst, done, error}, 32'b0100);
    expQ.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reset, model, send, then compare the final status against the model.
  task automatic run_load(input string name, input logic [7:0] b[$], input int feIdx, input int glitchAfter);
    int need;
    do_reset();
    model(b, feIdx);
    need = 2 + 2 * int'({b[0], b[1]});
`ifdef LOADER_CHECKSUM_EN
    need = need + 1;
`endif
    for (int i = 0; i < b.size(); i++) begin
      if (i < need) check({name, "_done_early"}, {31'd0, done}, 32'd0);
      send_byte(b[i], (i == feIdx) ? 1'b0 : 1'b1);
      if (i == glitchAfter) glitch();
    end
    repeat (3 * CPB) @(negedge clk);
    check({name, "_done"},   {31'd0, done},   {31'd0, expDone});
    check({name, "_error"},  {31'd0, error},  {31'd0, expErr});
    check({name, "_cpuRst"}, {31'd0, cpuRst}, {31'd0, ~expDone});
    check({name, "_writes_left"}, expQ.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] bq[$];
    int bad;

    // Reset hold with idle line.
    do_reset();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cpuRst !== 1'b1 || memBus.memWE !== 1'b0 || done !== 1'b0 || error !== 1'b0) bad++;
    end
    check("reset_hold_bad_cycles", bad, 0);

    // Pin the model with hand-derived expectations for the normal image.
    bq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'h40);  // 12^34^AB^CD
`endif
    model(bq, -1);
    check("model_nwrites", expQ.size(), 32'd2);
    check("model_w0", {expQ[0].addr, expQ[0].data}, 32'h0000_1234);
    check("model_w1", {expQ[1].addr, expQ[1].data}, 32'h0001_ABCD);
    check("model_done", {30'd0, expDone, expErr}, 32'b10);
    expQ.delete();

    run_load("normal", bq, -1, -1);
    check("normal_done_lit", {30'd0, done, cpuRst}, 32'b10);

    bq = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'h00);
`endif
    run_load("empty", bq, -1, -1);
    check("empty_done_lit", {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    bq = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00};
    model(bq, -1);
    check("model_badchk", {30'd0, expDone, expErr}, 32'b01);
    expQ.delete();
    run_load("badchk", bq, -1, -1);
    check("badchk_lit", {30'd0, error, cpuRst}, 32'b11);
`endif

    // Stop bit forced low on the second byte.
    bq = '{8'h00, 8'h02, 8'h12, 8'h34};
    run_load("framing", bq, 1, -1);
    check("framing_lit", {30'd0, error, done}, 32'b10);

    // One-cycle glitch between length and data must not create a byte.
    bq = '{8'h00, 8'h01, 8'h12, 8'h34};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'h26);
`endif
    run_load("glitch", bq, -1, 1);
    check("glitch_lit", {31'd0, done}, 32'd1);

    // Mid-load reset after 3 of 5 words, then a fresh single-word image.
    do_reset();
    bq = '{8'h00, 8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
    model(bq, -1);
    foreach (bq[i]) send_byte(bq[i], 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("midrst_writes_left", expQ.size(), 32'd0);
    check("midrst_before", {30'd0, done, cpuRst}, 32'b01);
    #2 rst = 1'b1;
    #1;
    check("midrst_memAddr", {16'd0, memBus.memAddr}, 32'd0);
    check("midrst_memData", {16'd0, memBus.memData}, 32'd0);
    check("midrst_flags", {28'd0, memBus.memWE, cpuRst, done, error}, 32'b0100);
    bq = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
    bq.push_back(8'h51);  // BE^EF
`endif
    run_load("reload", bq, -1, -1);
    check("reload_lit", {31'd0, done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
